proc_rf_wb_arbiter: RTL and testbench

Shares the single write port of the processor's 2r1w zero-register regfile between two writeback producers. Requester 0 is the main pipeline writeback; requester 1 is the long-latency iterative mul/div unit. Each requester has a one-entry buffer, and the block round-robin arbitrates among the buffered writes, issuing at most one regfile write per cycle. Query ports expose pending (buffered, not yet written) destinations so the decode stage can stall on RAW hazards.

---
 rtl/proc_rf_wb_arbiter.sv | 118 +++++++++++
 tb/tb_proc_rf_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_rf_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between pipeline and mul/div writeback.
// Optional stall statistics: define PROC_RF_WB_ARB_STATS_EN to build the conflict counter.
module proc_rf_wb_arbiter #(
    parameter int p_addr_nbits = 5,
    parameter int p_data_nbits = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [p_addr_nbits-1:0] req0_addr,
    input  logic [p_data_nbits-1:0] req0_data,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [p_addr_nbits-1:0] req1_addr,
    input  logic [p_data_nbits-1:0] req1_data,
    output logic                    wr_en,
    output logic [p_addr_nbits-1:0] wr_addr,
    output logic [p_data_nbits-1:0] wr_data,
    input  logic [p_addr_nbits-1:0] qry_addr0,
    output logic                    qry_pend0,
    input  logic [p_addr_nbits-1:0] qry_addr1,
    output logic                    qry_pend1,
    output logic                    busy,
    output logic [31:0]             conflict_count
);

    logic [1:0]              buf_val;
    logic [p_addr_nbits-1:0] buf_addr [2];
    logic [p_data_nbits-1:0] buf_data [2];
    logic                    prio;

    logic [1:0]              grant;
    logic                    flip;
    logic                    gidx;
    logic                    wr_hit;
    logic [1:0]              req_val;
    logic [1:0]              rdy;
    logic [p_addr_nbits-1:0] req_addr [2];
    logic [p_data_nbits-1:0] req_data [2];

    assign req_val     = {req1_val, req0_val};
    assign req_addr[0] = req0_addr;
    assign req_addr[1] = req1_addr;
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    // Same nonzero destination: the mul/div entry is older, so it must land first.
    always_comb begin
        grant = '0;
        flip  = 1'b0;
        if (buf_val == 2'b11) begin
            if (buf_addr[0] == buf_addr[1] && buf_addr[1] != '0) begin
                grant = 2'b10;
            end else begin
                grant = prio ? 2'b10 : 2'b01;
                flip  = 1'b1;
            end
        end else begin
            grant = buf_val;
        end
    end

    assign gidx   = grant[1];
    assign wr_hit = (|grant) && (buf_addr[gidx] != '0);

    assign rdy      = ~{2{reset}} & (~buf_val | grant);
    assign req0_rdy = rdy[0];
    assign req1_rdy = rdy[1];

    assign wr_en   = !reset && wr_hit;
    assign wr_addr = wr_en ? buf_addr[gidx] : '0;
    assign wr_data = wr_en ? buf_data[gidx] : '0;

    assign qry_pend0 = !reset && (qry_addr0 != '0) &&
                       ((buf_val[0] && buf_addr[0] == qry_addr0) ||
                        (buf_val[1] && buf_addr[1] == qry_addr0));
    assign qry_pend1 = !reset && (qry_addr1 != '0) &&
                       ((buf_val[0] && buf_addr[0] == qry_addr1) ||
                        (buf_val[1] && buf_addr[1] == qry_addr1));

    assign busy = !reset && (|buf_val);

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_val <= '0;
            prio    <= 1'b0;
        end else begin
            if (flip)
                prio <= ~prio;
            for (int unsigned i = 0; i < 2; i++) begin
                if (req_val[i] && rdy[i]) begin
                    buf_val[i]  <= 1'b1;
                    buf_addr[i] <= req_addr[i];
                    buf_data[i] <= req_data[i];
                end else if (grant[i]) begin
                    buf_val[i] <= 1'b0;
                end
            end
        end
    end

`ifdef PROC_RF_WB_ARB_STATS_EN
    logic [31:0] conflict_q;

    always_ff @(posedge clk) begin
        if (reset)
            conflict_q <= '0;
        else if ((&buf_val) && conflict_q != '1)
            conflict_q <= conflict_q + 32'd1;
    end

    assign conflict_count = conflict_q;
`else
    assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_proc_rf_wb_arbiter.sv
// Directed bench for proc_rf_wb_arbiter: rule-level model checked every cycle plus literal spot checks.
module tb_proc_rf_wb_arbiter;

`ifdef PROC_RF_WB_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_val = 1'b0, req1_val = 1'b0;
    logic        req0_rdy, req1_rdy;
    logic [4:0]  req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  qry_addr0 = '0, qry_addr1 = '0;
    logic        qry_pend0, qry_pend1, busy;
    logic [31:0] conflict_count;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    proc_rf_wb_arbiter #(.p_addr_nbits(5), .p_data_nbits(32)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_addr(req1_addr), .req1_data(req1_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .qry_addr0(qry_addr0), .qry_pend0(qry_pend0),
        .qry_addr1(qry_addr1), .qry_pend1(qry_pend1),
        .busy(busy), .conflict_count(conflict_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: two pending-write slots and a turn bit.
    logic        m_val [2] = '{1'b0, 1'b0};
    logic [4:0]  m_addr [2];
    logic [31:0] m_data [2];
    logic        m_turn = 1'b0;
    logic [31:0] m_cnt = '0;
    bit          m_init = 1'b0;

    typedef struct {
        logic        rdy0, rdy1, wen, p0, p1, bsy;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int          win;
        bit          rotate;
    } exp_t;

    function automatic bit pend(input logic [4:0] q);
        if (q == 0) return 1'b0;
        for (int i = 0; i < 2; i++)
            if (m_val[i] && m_addr[i] == q) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e = '{default: 0};
        e.win = -1;
        if (reset) return e;
        if (m_val[0] && m_val[1]) begin
            if (m_addr[0] == m_addr[1] && m_addr[0] != 0) e.win = 1;
            else begin e.win = int'(m_turn); e.rotate = 1'b1; end
        end else if (m_val[0]) e.win = 0;
        else if (m_val[1]) e.win = 1;
        e.rdy0 = !m_val[0] || e.win == 0;
        e.rdy1 = !m_val[1] || e.win == 1;
        if (e.win >= 0 && m_addr[e.win] != 0) begin
            e.wen   = 1'b1;
            e.waddr = m_addr[e.win];
            e.wdata = m_data[e.win];
        end
        e.p0  = pend(qry_addr0);
        e.p1  = pend(qry_addr1);
        e.bsy = m_val[0] || m_val[1];
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e = expect_now();
        m_init <= 1'b1;
        if (reset) begin
            m_val  <= '{1'b0, 1'b0};
            m_turn <= 1'b0;
            m_cnt  <= '0;
        end else begin
            if (STATS && m_val[0] && m_val[1] && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
            if (e.rotate) m_turn <= !m_turn;
            if (req0_val && e.rdy0) begin
                m_val[0] <= 1'b1; m_addr[0] <= req0_addr; m_data[0] <= req0_data;
            end else if (e.win == 0) m_val[0] <= 1'b0;
            if (req1_val && e.rdy1) begin
                m_val[1] <= 1'b1; m_addr[1] <= req1_addr; m_data[1] <= req1_data;
            end else if (e.win == 1) m_val[1] <= 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (m_init) begin
            e = expect_now();
            chk("m_req0_rdy", {31'b0, req0_rdy}, {31'b0, e.rdy0});
            chk("m_req1_rdy", {31'b0, req1_rdy}, {31'b0, e.rdy1});
            chk("m_wr_en",    {31'b0, wr_en},    {31'b0, e.wen});
            chk("m_wr_addr",  {27'b0, wr_addr},  {27'b0, e.waddr});
            chk("m_wr_data",  wr_data,           e.wdata);
            chk("m_qry_pend0", {31'b0, qry_pend0}, {31'b0, e.p0});
            chk("m_qry_pend1", {31'b0, qry_pend1}, {31'b0, e.p1});
            chk("m_busy",     {31'b0, busy},     {31'b0, e.bsy});
            chk("m_conflict", conflict_count,    m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic v, input logic [4:0] a, input logic [31:0] d);
        if (r == 0) begin req0_val = v; req0_addr = a; req0_data = d; end
        else        begin req1_val = v; req1_addr = a; req1_data = d; end
    endtask

    task automatic idle();
        drive(0, 1'b0, 5'd0, 32'd0);
        drive(1, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("rst_rdy0", {31'b0, req0_rdy}, 32'd0);
        reset = 1'b0;
        tick();

        // Single write, one-cycle latency
        drive(0, 1'b1, 5'd3, 32'hDEADBEEF);
        #1 chk("single_rdy0", {31'b0, req0_rdy}, 32'd1);
        tick(); idle();
        #1;
        chk("single_wr_en", {31'b0, wr_en}, 32'd1);
        chk("single_wr_addr", {27'b0, wr_addr}, 32'd3);
        chk("single_wr_data", wr_data, 32'hDEADBEEF);
        tick();
        chk("single_busy_after", {31'b0, busy}, 32'd0);

        // Contention with prio=0
        drive(0, 1'b1, 5'd5, 32'h11);
        drive(1, 1'b1, 5'd6, 32'h22);
        tick(); idle();
        qry_addr1 = 5'd6;
        #1;
        chk("cont_first_addr", {27'b0, wr_addr}, 32'd5);
        chk("cont_first_data", wr_data, 32'h11);
        chk("cont_rdy1_low", {31'b0, req1_rdy}, 32'd0);
        chk("cont_pend1", {31'b0, qry_pend1}, 32'd1);
        tick();
        chk("cont_second_addr", {27'b0, wr_addr}, 32'd6);
        chk("cont_second_data", wr_data, 32'h22);
        chk("cont_conflict", conflict_count, STATS ? 32'd1 : 32'd0);
        tick();
        qry_addr1 = 5'd0;

        // Same address: mul/div wins regardless of prio (now 1)
        drive(0, 1'b1, 5'd7, 32'hAAAA);
        drive(1, 1'b1, 5'd7, 32'hBBBB);
        tick(); idle();
        #1 chk("same_first_data", wr_data, 32'hBBBB);
        tick();
        chk("same_second_data", wr_data, 32'hAAAA);
        tick();

        // prio still 1 after same-address pair: requester 1 goes first
        drive(0, 1'b1, 5'd9, 32'h99);
        drive(1, 1'b1, 5'd10, 32'h1010);
        tick(); idle();
        #1 chk("prio1_first_addr", {27'b0, wr_addr}, 32'd10);
        tick();
        chk("prio1_second_addr", {27'b0, wr_addr}, 32'd9);
        chk("prio1_conflict", conflict_count, STATS ? 32'd3 : 32'd0);
        tick();

        // x0 write drains without a regfile write
        drive(1, 1'b1, 5'd0, 32'h55);
        #1 chk("x0_rdy1", {31'b0, req1_rdy}, 32'd1);
        tick(); idle();
        #1;
        chk("x0_wr_en", {31'b0, wr_en}, 32'd0);
        chk("x0_busy", {31'b0, busy}, 32'd1);
        chk("x0_pend0", {31'b0, qry_pend0}, 32'd0);
        tick();
        chk("x0_busy_after", {31'b0, busy}, 32'd0);

        // Streaming 1..8 on requester 0
        qry_addr0 = 5'd4;
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1'b1, 5'(i), 32'h100 + 32'(i));
            #1;
            chk("stream_rdy0", {31'b0, req0_rdy}, 32'd1);
            if (i > 1) begin
                chk("stream_wr_en", {31'b0, wr_en}, 32'd1);
                chk("stream_wr_addr", {27'b0, wr_addr}, 32'(i - 1));
            end
            if (i == 5) chk("stream_pend_r4", {31'b0, qry_pend0}, 32'd1);
            tick();
        end
        idle();
        #1;
        chk("stream_last_addr", {27'b0, wr_addr}, 32'd8);
        chk("stream_last_data", wr_data, 32'h108);
        tick();
        qry_addr0 = 5'd0;

        // Reset mid-operation discards both buffers
        drive(0, 1'b1, 5'd11, 32'hB0);
        drive(1, 1'b1, 5'd12, 32'hB1);
        tick(); idle();
        reset = 1'b1;
        #1;
        chk("midrst_wr_en", {31'b0, wr_en}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_wr_en_after", {31'b0, wr_en}, 32'd0);
        chk("midrst_conflict", conflict_count, 32'd0);
        drive(0, 1'b1, 5'd13, 32'hC0);
        drive(1, 1'b1, 5'd14, 32'hC1);
        tick(); idle();
        #1 chk("postrst_first_addr", {27'b0, wr_addr}, 32'd13);
        tick();
        chk("postrst_second_addr", {27'b0, wr_addr}, 32'd14);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
